// File: rtl/alu_issue_pkg.sv
// Shared constants, stage types and opcode helper for the ALU issue/writeback sequencer.
package alu_issue_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        f3;
        logic [6:0]        f7;
        logic [REG_AW-1:0] rd;
        logic              valid;
    } eStage_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              zero;
        logic [REG_AW-1:0] rd;
        logic              valid;
    } wStage_t;

    function automatic logic isAluOp(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_I);
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of instruction, regfile, ALU and writeback signals around alu_issue.
interface alu_issue_if
    import alu_issue_pkg::*;
#(
    parameter int XLEN    = DATA_W,
    parameter int RADDR_W = REG_AW
);
    logic [31:0]        iInstr;
    logic               iInstrValid;
    logic               oInstrReady;
    logic [RADDR_W-1:0] oRs1Addr;
    logic [RADDR_W-1:0] oRs2Addr;
    logic [XLEN-1:0]    iRs1Data;
    logic [XLEN-1:0]    iRs2Data;
    logic [XLEN-1:0]    oAluA;
    logic [XLEN-1:0]    oAluB;
    logic [2:0]         oAluFunct3;
    logic [6:0]         oAluFunct7;
    logic [XLEN-1:0]    iAluResult;
    logic               iAluZero;
    logic               oWbEn;
    logic [RADDR_W-1:0] oWbAddr;
    logic [XLEN-1:0]    oWbData;
    logic               oWbZero;
    logic               iWbReady;
    logic               oIllegal;

    modport master (
        input  iInstr, iInstrValid, iRs1Data, iRs2Data, iAluResult, iAluZero, iWbReady,
        output oInstrReady, oRs1Addr, oRs2Addr, oAluA, oAluB, oAluFunct3, oAluFunct7,
               oWbEn, oWbAddr, oWbData, oWbZero, oIllegal
    );

    modport slave (
        output iInstr, iInstrValid, iRs1Data, iRs2Data, iAluResult, iAluZero, iWbReady,
        input  oInstrReady, oRs1Addr, oRs2Addr, oAluA, oAluB, oAluFunct3, oAluFunct7,
               oWbEn, oWbAddr, oWbData, oWbZero, oIllegal
    );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I ALU-op decode: register fields, I-immediate, funct7 masking, illegal flag.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0]       instr,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [REG_AW-1:0] rd,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic [DATA_W-1:0] imm,
    output logic              useImm,
    output logic              illegal
);
    logic [6:0] opcode_s;

    // Field extraction and per-opcode operand/funct7 selection.
    always_comb begin
        opcode_s = instr[6:0];
        rs1      = instr[19:15];
        rs2      = instr[24:20];
        rd       = instr[11:7];
        funct3   = instr[14:12];
        imm      = {{(DATA_W-12){instr[31]}}, instr[31:20]};
        useImm   = 1'b0;
        funct7   = 7'd0;
        illegal  = !isAluOp(opcode_s);
        case (opcode_s)
            OP_R: begin
                useImm = 1'b0;
                funct7 = instr[31:25];
            end
            OP_I: begin
                useImm = 1'b1;
                // Only shifts carry a real funct7; masking keeps negative ADDI from looking like SUB.
                if ((funct3 == F3_SLL) || (funct3 == F3_SR)) begin
                    funct7 = instr[31:25];
                end else begin
                    funct7 = 7'd0;
                end
            end
            default: begin
                useImm = 1'b0;
                funct7 = 7'd0;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Operand-issue and writeback sequencer: decode/forward into E, present to external ALU, capture into W.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int XLEN    = DATA_W,
    parameter int RADDR_W = REG_AW
)(
    input  logic        iClk,
    input  logic        iRst,
    alu_issue_if.master bus
);
    localparam logic [RADDR_W-1:0] X0 = {RADDR_W{1'b0}};

    logic [RADDR_W-1:0] rs1_s;
    logic [RADDR_W-1:0] rs2_s;
    logic [RADDR_W-1:0] rd_s;
    logic [2:0]         funct3_s;
    logic [6:0]         funct7_s;
    logic [XLEN-1:0]    imm_s;
    logic               useImm_s;
    logic               illegal_s;

    logic [XLEN-1:0]    fwdA_s;
    logic [XLEN-1:0]    fwdB_s;
    logic [XLEN-1:0]    opB_s;

    logic               wbEn_s;
    logic               wFree_s;
    logic               eAdv_s;
    logic               ready_s;
    logic               accept_s;

    eStage_t            eReg_r;
    wStage_t            wReg_r;
    logic               illegal_r;

    alu_issue_decode u_decode (
        .instr   (bus.iInstr),
        .rs1     (rs1_s),
        .rs2     (rs2_s),
        .rd      (rd_s),
        .funct3  (funct3_s),
        .funct7  (funct7_s),
        .imm     (imm_s),
        .useImm  (useImm_s),
        .illegal (illegal_s)
    );

    // Operand forwarding: E result beats W data beats the regfile; W covers its own retiring cycle.
    always_comb begin
        fwdA_s = bus.iRs1Data;
        if (eReg_r.valid && (eReg_r.rd == rs1_s) && (rs1_s != X0)) begin
            fwdA_s = bus.iAluResult;
        end else if (wReg_r.valid && (wReg_r.rd == rs1_s) && (rs1_s != X0)) begin
            fwdA_s = wReg_r.data;
        end else begin
            fwdA_s = bus.iRs1Data;
        end

        fwdB_s = bus.iRs2Data;
        if (eReg_r.valid && (eReg_r.rd == rs2_s) && (rs2_s != X0)) begin
            fwdB_s = bus.iAluResult;
        end else if (wReg_r.valid && (wReg_r.rd == rs2_s) && (rs2_s != X0)) begin
            fwdB_s = wReg_r.data;
        end else begin
            fwdB_s = bus.iRs2Data;
        end

        if (useImm_s) begin
            opB_s = imm_s;
        end else begin
            opB_s = fwdB_s;
        end
    end

    // An rd==x0 entry in W never asserts oWbEn, so it frees the slot unconditionally.
    assign wbEn_s   = wReg_r.valid && (wReg_r.rd != X0);
    assign wFree_s  = !wReg_r.valid || (wbEn_s && bus.iWbReady) || (wReg_r.valid && (wReg_r.rd == X0));
    assign eAdv_s   = eReg_r.valid && wFree_s;
    assign ready_s  = !iRst && (!eReg_r.valid || wFree_s);
    assign accept_s = ready_s && bus.iInstrValid;

    // Execute register: loads legal accepted instructions, otherwise drains when it advances.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            eReg_r <= '0;
        end else if (accept_s && !illegal_s) begin
            eReg_r <= '{a: fwdA_s, b: opB_s, f3: funct3_s, f7: funct7_s, rd: rd_s, valid: 1'b1};
        end else if (eAdv_s) begin
            eReg_r.valid <= 1'b0;
        end else begin
            eReg_r <= eReg_r;
        end
    end

    // Writeback register: captures the ALU result as E advances, holds under backpressure.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wReg_r <= '0;
        end else if (eAdv_s) begin
            wReg_r <= '{data: bus.iAluResult, zero: bus.iAluZero, rd: eReg_r.rd, valid: 1'b1};
        end else if (wFree_s) begin
            wReg_r.valid <= 1'b0;
        end else begin
            wReg_r <= wReg_r;
        end
    end

    // One-cycle pulse following acceptance of a non-ALU opcode.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= accept_s && illegal_s;
        end
    end

    assign bus.oInstrReady = ready_s;
    assign bus.oRs1Addr    = rs1_s;
    assign bus.oRs2Addr    = rs2_s;
    assign bus.oAluA       = eReg_r.a;
    assign bus.oAluB       = eReg_r.b;
    assign bus.oAluFunct3  = eReg_r.f3;
    assign bus.oAluFunct7  = eReg_r.f7;
    assign bus.oWbEn       = wbEn_s;
    assign bus.oWbAddr     = wReg_r.rd;
    assign bus.oWbData     = wReg_r.data;
    assign bus.oWbZero     = wReg_r.zero;
    assign bus.oIllegal    = illegal_r;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus a random stream against an ISA-level model.
module tb_alu_issue;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wbExp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          nChecks = 0;
    int          nPass   = 0;
    bit          lastAcc;
    bit          illPrev;
    logic [31:0] rf   [32];
    logic [31:0] gold [32];
    wbExp_t      expQ [$];

    always #5 clk = ~clk;

    alu_issue_if #(.XLEN(32), .RADDR_W(5)) bus ();

    alu_issue #(.XLEN(32), .RADDR_W(5)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    function automatic logic [31:0] seedVal(input int i);
        return (i == 0) ? 32'd0 : (32'(i) * 32'h0100_0003);
    endfunction

    // Reference combinational ALU driven by the DUT's operand outputs.
    function automatic logic [31:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'd0:    return f7[5] ? (a - b) : (a + b);
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return f7[5] ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Architectural result of an RV32I OP / OP-IMM instruction.
    function automatic logic [31:0] isaExec(input logic [31:0] ins, input logic [31:0] v1, input logic [31:0] v2);
        logic        isR;
        logic [31:0] b;
        isR = (ins[6:0] == 7'b0110011);
        b   = isR ? v2 : {{20{ins[31]}}, ins[31:20]};
        case (ins[14:12])
            3'd0:    return (isR && ins[30]) ? (v1 - v2) : (v1 + b);
            3'd1:    return v1 << b[4:0];
            3'd2:    return ($signed(v1) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (v1 < b) ? 32'd1 : 32'd0;
            3'd4:    return v1 ^ b;
            3'd5:    return ins[30] ? 32'($signed(v1) >>> b[4:0]) : (v1 >> b[4:0]);
            3'd6:    return v1 | b;
            default: return v1 & b;
        endcase
    endfunction

    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    assign bus.iRs1Data   = rf[bus.oRs1Addr];
    assign bus.iRs2Data   = rf[bus.oRs2Addr];
    assign bus.iAluResult = aluRef(bus.oAluA, bus.oAluB, bus.oAluFunct3, bus.oAluFunct7);
    assign bus.iAluZero   = (bus.iAluResult == 32'd0);

    // Regfile model: seeded on reset, written on a completed writeback handshake.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= seedVal(i);
        end else if (bus.oWbEn && bus.iWbReady) begin
            rf[bus.oWbAddr] <= bus.oWbData;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // One clock: scoreboard at negedge (illegal pulse, writebacks, acceptances), return at posedge+1.
    task automatic tick();
        logic [31:0] ins;
        logic [31:0] res;
        wbExp_t      e;
        @(negedge clk);
        lastAcc = 1'b0;
        if (rst) begin
            expQ.delete();
            for (int i = 0; i < 32; i++) gold[i] = seedVal(i);
            illPrev = 1'b0;
        end else begin
            nChecks++;
            if (bus.oIllegal !== illPrev) $display("FAIL illegal_pulse: got %b expected %b", bus.oIllegal, illPrev);
            else nPass++;
            if (bus.oWbEn === 1'b1 && bus.iWbReady === 1'b1) begin
                nChecks++;
                if (expQ.size() == 0) begin
                    $display("FAIL wb_extra: got x%0d=%h expected no writeback", bus.oWbAddr, bus.oWbData);
                end else begin
                    e = expQ.pop_front();
                    if ({bus.oWbAddr, bus.oWbData, bus.oWbZero} !== {e.rd, e.data, (e.data == 32'd0)})
                        $display("FAIL wb_data: got x%0d=%h z=%b expected x%0d=%h z=%b",
                                 bus.oWbAddr, bus.oWbData, bus.oWbZero, e.rd, e.data, (e.data == 32'd0));
                    else nPass++;
                end
            end
            illPrev = 1'b0;
            if (bus.iInstrValid && bus.oInstrReady) begin
                lastAcc = 1'b1;
                ins = bus.iInstr;
                if (ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0010011) begin
                    res = isaExec(ins, gold[ins[19:15]], gold[ins[24:20]]);
                    if (ins[11:7] != 5'd0) begin
                        gold[ins[11:7]] = res;
                        expQ.push_back('{rd: ins[11:7], data: res});
                    end
                end else begin
                    illPrev = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins);
        bus.iInstr      = ins;
        bus.iInstrValid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (lastAcc) break;
        end
        nChecks++;
        if (!lastAcc) $display("FAIL issue_timeout: got no accept for %h, expected accept", ins);
        else nPass++;
    endtask

    task automatic drain();
        bus.iInstrValid = 1'b0;
        bus.iWbReady    = 1'b1;
        for (int k = 0; k < 20 && expQ.size() > 0; k++) tick();
        tick();
        nChecks++;
        if (expQ.size() != 0) $display("FAIL drain: got %0d pending writebacks, expected 0", expQ.size());
        else nPass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.iInstrValid = 1'b0;
        bus.iInstr      = 32'd0;
        bus.iWbReady    = 1'b1;
        tick();
        tick();
        nChecks++;
        if (bus.oInstrReady !== 1'b0) $display("FAIL rst_ready_low: got %b expected 0", bus.oInstrReady);
        else nPass++;
        nChecks++;
        if ({bus.oAluA, bus.oAluB, bus.oAluFunct3, bus.oAluFunct7, bus.oWbEn, bus.oWbAddr,
             bus.oWbData, bus.oWbZero, bus.oIllegal} !== 114'd0)
            $display("FAIL rst_outputs: got A=%h B=%h wb=%b x%0d=%h expected all 0",
                     bus.oAluA, bus.oAluB, bus.oWbEn, bus.oWbAddr, bus.oWbData);
        else nPass++;
        rst = 1'b0;
        #1;
        nChecks++;
        if (bus.oInstrReady !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", bus.oInstrReady);
        else nPass++;
    endtask

    task automatic test_back_to_back();
        issue(32'h00500093);
        issue(32'h00108133);
        bus.iInstrValid = 1'b0;
        nChecks++;
        if ({bus.oAluA, bus.oAluB, bus.oAluFunct3, bus.oAluFunct7} !== {32'd5, 32'd5, 3'd0, 7'd0})
            $display("FAIL b2b_fwd_e: got A=%h B=%h f3=%h f7=%h expected A=5 B=5 f3=0 f7=0",
                     bus.oAluA, bus.oAluB, bus.oAluFunct3, bus.oAluFunct7);
        else nPass++;
        nChecks++;
        if ({bus.oWbEn, bus.oWbAddr, bus.oWbData} !== {1'b1, 5'd1, 32'd5})
            $display("FAIL b2b_wb_x1: got en=%b x%0d=%h expected en=1 x1=5", bus.oWbEn, bus.oWbAddr, bus.oWbData);
        else nPass++;
        tick();
        nChecks++;
        if ({bus.oWbEn, bus.oWbAddr, bus.oWbData} !== {1'b1, 5'd2, 32'd10})
            $display("FAIL b2b_wb_x2: got en=%b x%0d=%h expected en=1 x2=10", bus.oWbEn, bus.oWbAddr, bus.oWbData);
        else nPass++;
        // One bubble apart: producer sits in W and retires on the consumer's accept edge.
        issue(encI(12'd3, 5'd0, 3'd0, 5'd6));
        bus.iInstrValid = 1'b0;
        tick();
        issue(encR(7'd0, 5'd6, 5'd6, 3'd0, 5'd7));
        bus.iInstrValid = 1'b0;
        nChecks++;
        if ({bus.oAluA, bus.oAluB} !== {32'd3, 32'd3})
            $display("FAIL fwd_w: got A=%h B=%h expected A=3 B=3", bus.oAluA, bus.oAluB);
        else nPass++;
        drain();
    endtask

    task automatic test_addi();
        issue(32'h00500093);
        bus.iInstrValid = 1'b0;
        nChecks++;
        if ({bus.oAluA, bus.oAluB, bus.oAluFunct7} !== {32'd0, 32'd5, 7'd0})
            $display("FAIL addi_exec: got A=%h B=%h f7=%h expected A=0 B=5 f7=0", bus.oAluA, bus.oAluB, bus.oAluFunct7);
        else nPass++;
        tick();
        nChecks++;
        if ({bus.oWbEn, bus.oWbAddr, bus.oWbData, bus.oWbZero} !== {1'b1, 5'd1, 32'd5, 1'b0})
            $display("FAIL addi_wb: got en=%b x%0d=%h z=%b expected en=1 x1=5 z=0",
                     bus.oWbEn, bus.oWbAddr, bus.oWbData, bus.oWbZero);
        else nPass++;
        drain();
    endtask

    task automatic test_imm_funct7();
        issue(32'hFFF00093);
        nChecks++;
        if ({bus.oAluB, bus.oAluFunct3, bus.oAluFunct7} !== {32'hFFFF_FFFF, 3'd0, 7'd0})
            $display("FAIL neg_addi: got B=%h f3=%h f7=%h expected B=ffffffff f3=0 f7=0",
                     bus.oAluB, bus.oAluFunct3, bus.oAluFunct7);
        else nPass++;
        issue(32'h4040D193);
        bus.iInstrValid = 1'b0;
        nChecks++;
        if ({bus.oAluA, bus.oAluB, bus.oAluFunct3, bus.oAluFunct7} !== {32'hFFFF_FFFF, 32'h0000_0404, 3'b101, 7'b0100000})
            $display("FAIL srai: got A=%h B=%h f3=%h f7=%h expected A=ffffffff B=404 f3=5 f7=20",
                     bus.oAluA, bus.oAluB, bus.oAluFunct3, bus.oAluFunct7);
        else nPass++;
        drain();
    endtask

    task automatic test_backpressure();
        bus.iWbReady = 1'b0;
        issue(encI(12'd1, 5'd0, 3'd0, 5'd8));
        issue(encI(12'd2, 5'd0, 3'd0, 5'd9));
        bus.iInstr = encI(12'd3, 5'd0, 3'd0, 5'd10);
        tick();
        nChecks++;
        if (bus.oInstrReady !== 1'b0) $display("FAIL bp_ready_drop: got %b expected 0", bus.oInstrReady);
        else nPass++;
        nChecks++;
        if ({bus.oWbEn, bus.oWbAddr, bus.oWbData} !== {1'b1, 5'd8, 32'd1})
            $display("FAIL bp_hold: got en=%b x%0d=%h expected en=1 x8=1", bus.oWbEn, bus.oWbAddr, bus.oWbData);
        else nPass++;
        bus.iWbReady = 1'b1;
        issue(encI(12'd3, 5'd0, 3'd0, 5'd10));
        issue(encI(12'd4, 5'd0, 3'd0, 5'd11));
        drain();
    endtask

    task automatic test_illegal_x0();
        bus.iWbReady = 1'b1;
        issue(32'h0000006F);
        bus.iInstrValid = 1'b0;
        nChecks++;
        if (bus.oIllegal !== 1'b1) $display("FAIL jal_pulse: got %b expected 1", bus.oIllegal);
        else nPass++;
        tick();
        nChecks++;
        if ({bus.oIllegal, bus.oWbEn} !== 2'b00)
            $display("FAIL jal_after: got ill=%b wb=%b expected 0 0", bus.oIllegal, bus.oWbEn);
        else nPass++;
        bus.iWbReady = 1'b0;
        issue(32'h00700013);
        issue(encI(12'd1, 5'd0, 3'd0, 5'd12));
        bus.iInstr = encI(12'd2, 5'd0, 3'd0, 5'd13);
        #1;
        nChecks++;
        if ({bus.oInstrReady, bus.oWbEn} !== 2'b10)
            $display("FAIL x0_no_stall: got ready=%b wb=%b expected ready=1 wb=0", bus.oInstrReady, bus.oWbEn);
        else nPass++;
        bus.iWbReady = 1'b1;
        issue(encI(12'd2, 5'd0, 3'd0, 5'd13));
        drain();
    endtask

    task automatic test_reset_midstream();
        bus.iWbReady = 1'b0;
        issue(encI(12'd7, 5'd0, 3'd0, 5'd14));
        issue(encI(12'd8, 5'd0, 3'd0, 5'd15));
        bus.iInstrValid = 1'b0;
        rst = 1'b1;
        #1;
        nChecks++;
        if (bus.oInstrReady !== 1'b0) $display("FAIL mid_rst_ready: got %b expected 0", bus.oInstrReady);
        else nPass++;
        tick();
        rst = 1'b0;
        bus.iWbReady = 1'b1;
        #1;
        nChecks++;
        if ({bus.oAluA, bus.oAluB, bus.oAluFunct3, bus.oAluFunct7, bus.oWbEn, bus.oWbAddr,
             bus.oWbData, bus.oWbZero, bus.oIllegal, bus.oInstrReady} !== {114'd0, 1'b1})
            $display("FAIL mid_rst_outputs: got A=%h wb=%b x%0d=%h ready=%b expected zeros ready=1",
                     bus.oAluA, bus.oWbEn, bus.oWbAddr, bus.oWbData, bus.oInstrReady);
        else nPass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            nChecks++;
            if (bus.oWbEn !== 1'b0) $display("FAIL mid_rst_no_wb: got %b expected 0", bus.oWbEn);
            else nPass++;
        end
        issue(encR(7'd0, 5'd15, 5'd14, 3'd0, 5'd16));
        drain();
    endtask

    function automatic logic [31:0] randInstr();
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  f7;
        int          kind;
        kind = $urandom_range(0, 9);
        rd   = 5'($urandom_range(0, 7));
        rs1  = 5'($urandom_range(0, 7));
        rs2  = 5'($urandom_range(0, 7));
        f3   = 3'($urandom_range(0, 7));
        imm  = 12'($urandom);
        if (kind == 0) begin
            return {25'($urandom), ($urandom_range(0, 1) != 0) ? 7'b1101111 : 7'b0110111};
        end else if (kind < 5) begin
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            return encR(f7, rs2, rs1, f3, rd);
        end else begin
            if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
            if (f3 == 3'd5) imm = {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, imm[4:0]};
            return encI(imm, rs1, f3, rd);
        end
    endfunction

    task automatic test_random();
        logic [31:0] cur;
        bit          have;
        have = 1'b0;
        cur  = 32'd0;
        for (int c = 0; c < 400; c++) begin
            if (!have) begin
                cur  = randInstr();
                have = 1'b1;
            end
            bus.iInstr      = cur;
            bus.iInstrValid = ($urandom_range(0, 3) != 0);
            bus.iWbReady    = ($urandom_range(0, 4) != 0);
            tick();
            if (lastAcc) have = 1'b0;
        end
        drain();
    endtask

    initial begin
        rst             = 1'b1;
        bus.iInstr      = 32'd0;
        bus.iInstrValid = 1'b0;
        bus.iWbReady    = 1'b1;
        illPrev         = 1'b0;
        lastAcc         = 1'b0;
        test_reset();
        test_back_to_back();
        test_addi();
        test_imm_funct7();
        test_backpressure();
        test_illegal_x0();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
